// File: rtl/divisor_restaurador.sv
// rtl/divisor_restaurador.sv - sequential signed restoring divider, 2N/N -> N quotient + N remainder
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, priority over start
//   start      level request, sampled only in IDLE or FIN
//   dividendo  2N-bit signed dividend, captured when start is accepted
//   divisor    N-bit signed divisor, captured when start is accepted
//   cociente   N-bit signed quotient (truncated toward zero), valid while fin=1
//   resto      N-bit signed remainder with the dividend's sign, valid while fin=1
//   fin        result valid, held until the next accepted start
//   error      qualified by fin: divide-by-zero or quotient overflow

module divisor_restaurador #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2*N-1:0]   dividendo,
    input  logic [N-1:0]     divisor,
    output logic [N-1:0]     cociente,
    output logic [N-1:0]     resto,
    output logic             fin,
    output logic             error
);

    localparam int W2 = 2 * N;
    localparam int CW = $clog2(W2 + 1);

    // Largest quotient magnitudes representable in N signed bits.
    localparam logic [W2-1:0] Q_POS_MAG = W2'((1 << (N - 1)) - 1);
    localparam logic [W2-1:0] Q_NEG_MAG = W2'(1 << (N - 1));

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CARGA  = 3'd1,
        DIVIDE = 3'd2,
        AJUSTE = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t state, state_nxt;

    // dvd_q holds the raw dividend until CARGA, then its magnitude, which
    // shifts out of the top while quotient bits shift in at the bottom.
    logic [W2-1:0] dvd_q, dvd_d;
    // dvs_q holds the raw divisor until CARGA, then its magnitude.
    logic [N-1:0]  dvs_q, dvs_d;
    // After each restore the remainder is below |divisor|, so N bits hold it;
    // the N+1-bit working value is formed in shifted/trial.
    logic [N-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sq_q, sq_d;
    logic          sr_q, sr_d;
    logic [N-1:0]  coc_d, res_d;
    logic          fin_d, err_d;

    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic [N-1:0]  q_low;
    logic          q_ovf;

    assign shifted = {rem_q, dvd_q[W2-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    // Low bits of a negation depend only on the low bits of the operand.
    assign q_low   = sq_q ? -dvd_q[N-1:0] : dvd_q[N-1:0];
    // A negative quotient may reach one more in magnitude than a positive one.
    assign q_ovf   = sq_q ? (dvd_q > Q_NEG_MAG) : (dvd_q > Q_POS_MAG);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                if (start) begin
                    state_nxt = CARGA;
                end
            end
            CARGA: begin
                state_nxt = (dvs_q == '0) ? FIN : DIVIDE;
            end
            DIVIDE: begin
                if (cnt_q == CW'(1)) begin
                    state_nxt = AJUSTE;
                end
            end
            AJUSTE: begin
                state_nxt = FIN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        sq_d  = sq_q;
        sr_d  = sr_q;
        coc_d = cociente;
        res_d = resto;
        fin_d = fin;
        err_d = error;
        case (state)
            IDLE, FIN: begin
                if (start) begin
                    dvd_d = dividendo;
                    dvs_d = divisor;
                    fin_d = 1'b0;
                    err_d = 1'b0;
                end
            end
            CARGA: begin
                sq_d  = dvd_q[W2-1] ^ dvs_q[N-1];
                sr_d  = dvd_q[W2-1];
                // The most negative dividend negates to itself, which read
                // unsigned is exactly its magnitude.
                dvd_d = dvd_q[W2-1] ? -dvd_q : dvd_q;
                dvs_d = dvs_q[N-1] ? -dvs_q : dvs_q;
                rem_d = '0;
                cnt_d = CW'(W2);
                if (dvs_q == '0) begin
                    err_d = 1'b1;
                    coc_d = '0;
                    res_d = '0;
                    fin_d = 1'b1;
                end
            end
            DIVIDE: begin
                if (!trial[N]) begin
                    rem_d = trial[N-1:0];
                    dvd_d = {dvd_q[W2-2:0], 1'b1};
                end else begin
                    rem_d = shifted[N-1:0];
                    dvd_d = {dvd_q[W2-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
            end
            AJUSTE: begin
                fin_d = 1'b1;
                if (q_ovf) begin
                    err_d = 1'b1;
                    coc_d = '0;
                    res_d = '0;
                end else begin
                    coc_d = q_low;
                    res_d = sr_q ? -rem_q : rem_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sq_q     <= 1'b0;
            sr_q     <= 1'b0;
            cociente <= '0;
            resto    <= '0;
            fin      <= 1'b0;
            error    <= 1'b0;
        end else begin
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sq_q     <= sq_d;
            sr_q     <= sr_d;
            cociente <= coc_d;
            resto    <= res_d;
            fin      <= fin_d;
            error    <= err_d;
        end
    end

endmodule

// File: tb/tb_divisor_restaurador.sv
// tb/tb_divisor_restaurador.sv - directed self-checking bench for divisor_restaurador (N=3)

module tb_divisor_restaurador;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic [N-1:0]   cociente;
    logic [N-1:0]   resto;
    logic           fin;
    logic           error;

    int checks = 0;
    int errors = 0;

    divisor_restaurador #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .cociente  (cociente),
        .resto     (resto),
        .fin       (fin),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts edges from the accepting edge until fin, bounded.
    task automatic wait_fin(input bit toggle, output int lat);
        lat = 0;
        while (fin !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (toggle && fin !== 1'b1) start = lat[0];
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                          input int exp_lat, input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                          input logic exp_e, input bit toggle);
        int lat;
        dividendo = dvd;
        divisor   = dvs;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        dividendo = ~dvd;
        divisor   = ~dvs;
        chk({tag, "_fin_clr"}, {31'd0, fin}, 32'd0);
        wait_fin(toggle, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, {29'd0, cociente}, {29'd0, exp_q});
        chk({tag, "_r"}, {29'd0, resto}, {29'd0, exp_r});
        chk({tag, "_err"}, {31'd0, error}, {31'd0, exp_e});
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        start     = 1'b1;
        dividendo = 6'd7;
        divisor   = 3'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fin", {31'd0, fin}, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_q", {29'd0, cociente}, 32'd0);
        chk("rst_r", {29'd0, resto}, 32'd0);
        start = 1'b0;
        reset = 1'b0;

        run_op("p7d3",    6'd7,      3'd3,    8, 3'b010, 3'b001, 1'b0, 1'b0);
        run_op("m7d3",    6'b111001, 3'd3,    8, 3'b110, 3'b111, 1'b0, 1'b0);
        run_op("m8d2",    6'b111000, 3'd2,    8, 3'b100, 3'b000, 1'b0, 1'b0);
        run_op("p6dm3",   6'd6,      3'b101,  8, 3'b110, 3'b000, 1'b0, 1'b0);
        run_op("ovf13d3", 6'd13,     3'd3,    8, 3'b000, 3'b000, 1'b1, 1'b0);
        run_op("ovfm32",  6'b100000, 3'b111,  8, 3'b000, 3'b000, 1'b1, 1'b0);
        run_op("m7dm4",   6'b111001, 3'b100,  8, 3'b001, 3'b101, 1'b0, 1'b0);
        run_op("div0",    6'd5,      3'd0,    1, 3'b000, 3'b000, 1'b1, 1'b0);
        run_op("toggle",  6'd7,      3'd3,    8, 3'b010, 3'b001, 1'b0, 1'b1);

        // Reset in the 4th DIVIDE cycle clears everything.
        dividendo = 6'b111001;
        divisor   = 3'd3;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_fin", {31'd0, fin}, 32'd0);
        chk("midrst_err", {31'd0, error}, 32'd0);
        chk("midrst_q", {29'd0, cociente}, 32'd0);
        chk("midrst_r", {29'd0, resto}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_idle_fin", {31'd0, fin}, 32'd0);
        run_op("after_rst", 6'd7, 3'd3, 8, 3'b010, 3'b001, 1'b0, 1'b0);

        // Back-to-back with start held high.
        dividendo = 6'd6;
        divisor   = 3'd2;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (fin !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("b2b1_lat", lat, 8);
        chk("b2b1_q", {29'd0, cociente}, 32'd3);
        chk("b2b1_r", {29'd0, resto}, 32'd0);
        dividendo = 6'b111011;
        divisor   = 3'd2;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_fin_drop", {31'd0, fin}, 32'd0);
        chk("b2b_q_held", {29'd0, cociente}, 32'd3);
        lat = 0;
        while (fin !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("b2b2_lat", lat, 8);
        chk("b2b2_q", {29'd0, cociente}, {29'd0, 3'b110});
        chk("b2b2_r", {29'd0, resto}, {29'd0, 3'b111});
        chk("b2b2_err", {31'd0, error}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b2b_hold_fin", {31'd0, fin}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
